rom_select_ctrl: RTL and testbench

- Front-panel ROM-select controller upstream of the flash-backed memory loader.
- Synchronises and debounces raw active-low select buttons plus a shift button.
- On release of the select buttons, emits a one-cycle reload pulse with a latched 4-bit ROM index.
- Then blocks further requests until the loader reports completion through load_done.

---
 rtl/rom_select_if.sv | 30 +++
 rtl/rom_select_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_rom_select_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_select_if.sv
// Front-panel ROM-select bundle: raw buttons and loader status in,
// reload request, ROM index, busy and debounced button state out.
interface rom_select_if #(
  parameter int N_SEL = 4
) ();
  logic [N_SEL:0] btn_n;
  logic           load_done;
  logic           reload;
  logic [3:0]     index;
  logic           busy;
  logic [N_SEL:0] pressed;

  modport master (
    input  btn_n,
    input  load_done,
    output reload,
    output index,
    output busy,
    output pressed
  );

  modport slave (
    output btn_n,
    output load_done,
    input  reload,
    input  index,
    input  busy,
    input  pressed
  );
endinterface

// File: rtl/rom_select_ctrl.sv
// ROM-select controller: synchronise and debounce panel buttons, then
// issue one reload pulse with a latched index and wait for the loader.
module rom_select_ctrl #(
  parameter int N_SEL        = 4,
  parameter int DB_MAX       = 50000,
  parameter int DB_W         = 16,
  parameter int DROP_TIMEOUT = 15
) (
  input logic          clock,
  input logic          reset_n,
  rom_select_if.master bus
);

  localparam int NB = N_SEL + 1;
  localparam int TW = $clog2(DROP_TIMEOUT + 1);
  localparam logic [DB_W-1:0] CNT_TOP = DB_W'(DB_MAX - 1);
  localparam logic [TW-1:0]   T_TOP   = TW'(DROP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_PULSE,
    S_WDROP,
    S_WDONE
  } state_t;

  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] w_s;
  logic [NB-1:0] r_pressed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  for (genvar g = 0; g < NB; g++) begin : g_db
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt        <= '0;
        r_pressed[g] <= 1'b0;
      end else if (w_s[g] == r_pressed[g]) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_TOP) begin
        r_cnt        <= '0;
        r_pressed[g] <= w_s[g];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  logic [3:0] w_sel;
  logic [3:0] w_oh;
  logic [1:0] w_low;
  logic       w_any;
  logic       w_shift;

  assign w_sel   = r_pressed[3:0];
  assign w_any   = |w_sel;
  assign w_shift = r_pressed[N_SEL];
  // isolate the lowest held select so bit 0 wins
  assign w_oh    = w_sel & (~w_sel + 4'd1);

  always_comb begin
    w_low = 2'd0;
    unique case (1'b1)
      w_oh[0]: w_low = 2'd0;
      w_oh[1]: w_low = 2'd1;
      w_oh[2]: w_low = 2'd2;
      w_oh[3]: w_low = 2'd3;
      default: w_low = 2'd0;
    endcase
  end

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_cand;
  logic          r_cshift;
  logic [TW-1:0] r_timer;
  logic          r_reload;
  logic [3:0]    r_index;
  logic          r_busy;

  logic [1:0]    w_cand_d;
  logic          w_cshift_d;
  logic [TW-1:0] w_timer_d;
  logic          w_reload_d;
  logic [3:0]    w_index_d;
  logic          w_busy_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cand   <= '0;
      r_cshift <= 1'b0;
      r_timer  <= '0;
      r_reload <= 1'b0;
      r_index  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cand   <= w_cand_d;
      r_cshift <= w_cshift_d;
      r_timer  <= w_timer_d;
      r_reload <= w_reload_d;
      r_index  <= w_index_d;
      r_busy   <= w_busy_d;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ARMED;
      S_ARMED: if (!w_any) w_next = S_PULSE;
      S_PULSE: w_next = S_WDROP;
      S_WDROP: begin
        if (!bus.load_done)     w_next = S_WDONE;
        else if (r_timer == T_TOP) w_next = S_IDLE;
      end
      S_WDONE: if (bus.load_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // reload/index are loaded on entry to PULSE so both change together
  always_comb begin
    w_reload_d = (w_next == S_PULSE);
    w_index_d  = r_index;
    w_busy_d   = r_busy;
    w_cand_d   = r_cand;
    w_cshift_d = r_cshift;
    w_timer_d  = r_timer;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_cand_d   = w_low;
          w_cshift_d = w_shift;
        end
      end
      S_ARMED: begin
        if (w_any) begin
          w_cand_d   = w_low;
          w_cshift_d = r_cshift | w_shift;
        end else begin
          w_index_d = {1'b0, r_cshift, r_cand};
          w_busy_d  = 1'b1;
          w_timer_d = '0;
        end
      end
      S_PULSE: w_timer_d = '0;
      S_WDROP: begin
        if (bus.load_done) begin
          if (r_timer == T_TOP) w_busy_d = 1'b0;
          else                  w_timer_d = r_timer + 1'b1;
        end
      end
      S_WDONE: begin
        if (bus.load_done) w_busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.reload  = r_reload;
  assign bus.index   = r_index;
  assign bus.busy    = r_busy;
  assign bus.pressed = r_pressed;

endmodule

// File: tb/tb_rom_select_ctrl.sv
// Bench for rom_select_ctrl: vector table, corner sequences and random
// button traffic checked every cycle against a behavioural model.
module tb_rom_select_ctrl;

  localparam int NSEL = 4;
  localparam int DBM  = 4;
  localparam int DT   = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rom_select_if #(.N_SEL(NSEL)) bus ();

  rom_select_ctrl #(
    .N_SEL(NSEL),
    .DB_MAX(DBM),
    .DB_W(16),
    .DROP_TIMEOUT(DT)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_pulse = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  logic [4:0] m_d0, m_d1, m_pr;
  logic [4:0] m_h [DBM];
  int         m_mode;
  int         m_t;
  logic [1:0] m_cand;
  logic       m_cs;
  logic [3:0] m_idx;
  logic       m_busy;

  function automatic logic [1:0] lowest(logic [4:0] p);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (p[i]) r = 2'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_d0 = '1;
    m_d1 = '1;
    m_pr = '0;
    for (int j = 0; j < DBM; j++) m_h[j] = '0;
    m_mode = 0;
    m_t = 0;
    m_cand = '0;
    m_cs = 1'b0;
    m_idx = '0;
    m_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [4:0] s;
    logic [4:0] p;
    logic all;
    s = ~m_d1;
    m_d1 = m_d0;
    m_d0 = bus.btn_n;
    p = m_pr;
    case (m_mode)
      0: if (|p[3:0]) begin
        m_cand = lowest(p);
        m_cs = p[4];
        m_mode = 1;
      end
      1: if (|p[3:0]) begin
        m_cand = lowest(p);
        m_cs = m_cs | p[4];
      end else begin
        m_idx = {1'b0, m_cs, m_cand};
        m_busy = 1'b1;
        m_mode = 2;
      end
      2: begin
        m_mode = 3;
        m_t = 0;
      end
      3: if (!bus.load_done) m_mode = 4;
      else begin
        m_t++;
        if (m_t == DT) begin
          m_mode = 0;
          m_busy = 1'b0;
        end
      end
      4: if (bus.load_done) begin
        m_mode = 0;
        m_busy = 1'b0;
      end
      default: m_mode = 0;
    endcase
    for (int j = DBM - 1; j > 0; j--) m_h[j] = m_h[j-1];
    m_h[0] = s;
    // a bit flips once its last DBM synchronised samples all disagree
    for (int i = 0; i < 5; i++) begin
      all = 1'b1;
      for (int j = 0; j < DBM; j++) if (m_h[j][i] == m_pr[i]) all = 1'b0;
      if (all) m_pr[i] = s[i];
    end
  endtask

  // loader stand-in
  int ld_mode = 0;
  int lph = 0;
  int lcnt = 0;

  task automatic loader_update();
    if (m_mode == 2) begin
      lph  = (ld_mode == 1) ? 0 : 1;
      lcnt = (ld_mode == 2) ? int'($urandom_range(0, 20)) : 2;
    end else if (lph == 1) begin
      if (lcnt == 0) begin
        bus.load_done = 1'b0;
        lph = 2;
        lcnt = (ld_mode == 3) ? 30 :
               (ld_mode == 2) ? int'($urandom_range(0, 20)) : 10;
      end else lcnt--;
    end else if (lph == 2) begin
      if (lcnt == 0) begin
        bus.load_done = 1'b1;
        lph = 0;
      end else lcnt--;
    end
  endtask

  task automatic tick();
    logic mr;
    @(negedge clk);
    model_step();
    mr = (m_mode == 2);
    chk("cyc", {bus.reload, bus.index, bus.busy, bus.pressed},
        {mr, m_idx, m_busy, m_pr});
    if (bus.reload) n_pulse++;
    loader_update();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    lph = 0;
    bus.load_done = 1'b1;
    chk("rst_async", {bus.reload, bus.index, bus.busy, bus.pressed}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_reload(string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (bus.reload) seen = 1'b1;
    end
    chk(name, {31'b0, seen}, 32'h1);
  endtask

  typedef struct {
    logic [4:0] press;
    int         hold;
    int         np;
    logic [3:0] idx;
  } vec_t;

  vec_t vt [8];
  int   p0;
  int   rise;
  int   bc;

  initial begin
    vt[0] = '{5'b00100,  3, 0, 4'b0010};
    vt[1] = '{5'b00100, 20, 1, 4'b0010};
    vt[2] = '{5'b10010, 20, 1, 4'b0101};
    vt[3] = '{5'b01001, 20, 1, 4'b0000};
    vt[4] = '{5'b10000, 20, 0, 4'b0000};
    vt[5] = '{5'b01000, 20, 1, 4'b0011};
    vt[6] = '{5'b11000, 20, 1, 4'b0111};
    vt[7] = '{5'b00110, 20, 1, 4'b0001};

    bus.btn_n = '1;
    bus.load_done = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset", {bus.reload, bus.index, bus.busy, bus.pressed}, 32'h0);
    rst_n = 1'b1;

    p0 = n_pulse;
    repeat (100) tick();
    chk("idle_no_pulse", n_pulse - p0, 0);

    // debounce latency of a clean press
    bus.btn_n[2] = 1'b0;
    rise = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.pressed[2] && rise == 0) rise = k;
    end
    chk("rise_edges", rise, DBM + 2);
    bus.btn_n = '1;
    repeat (60) tick();
    chk("rise_pulses", n_pulse - p0, 1);
    chk("rise_idx", bus.index, 4'b0010);

    for (int i = 0; i < 8; i++) begin
      ld_mode = 0;
      p0 = n_pulse;
      bus.btn_n = ~vt[i].press;
      repeat (vt[i].hold) tick();
      bus.btn_n = '1;
      repeat (60) tick();
      chk($sformatf("vec%0d_pulses", i), n_pulse - p0, vt[i].np);
      chk($sformatf("vec%0d_idx", i), bus.index, vt[i].idx);
    end

    // shift held around a select press
    p0 = n_pulse;
    bus.btn_n[4] = 1'b0;
    repeat (10) tick();
    bus.btn_n[1] = 1'b0;
    repeat (10) tick();
    bus.btn_n[1] = 1'b1;
    repeat (10) tick();
    bus.btn_n[4] = 1'b1;
    repeat (50) tick();
    chk("shift_pulses", n_pulse - p0, 1);
    chk("shift_idx", bus.index, 4'b0101);

    // press during busy is ignored
    ld_mode = 3;
    p0 = n_pulse;
    bus.btn_n[3] = 1'b0;
    repeat (10) tick();
    bus.btn_n[3] = 1'b1;
    wait_reload("busy_seen");
    bus.btn_n[1] = 1'b0;
    repeat (10) tick();
    bus.btn_n[1] = 1'b1;
    chk("busy_mid", {31'b0, bus.busy}, 32'h1);
    repeat (100) tick();
    chk("busy_pulses", n_pulse - p0, 1);
    chk("busy_idx", bus.index, 4'b0011);

    // loader never drops load_done
    ld_mode = 1;
    bus.btn_n[0] = 1'b0;
    repeat (10) tick();
    bus.btn_n[0] = 1'b1;
    wait_reload("tmo_seen");
    bc = bus.busy ? 1 : 0;
    repeat (40) begin
      tick();
      if (bus.busy) bc++;
    end
    chk("tmo_busy_cycles", bc, DT + 1);

    // reset while waiting for the loader to finish
    ld_mode = 3;
    bus.btn_n[2] = 1'b0;
    repeat (10) tick();
    bus.btn_n[2] = 1'b1;
    for (int k = 0; k < 60 && m_mode != 4; k++) tick();
    chk("wdone_reached", {31'b0, bus.busy & ~bus.load_done}, 32'h1);
    repeat (3) tick();
    async_reset();
    ld_mode = 0;
    p0 = n_pulse;
    repeat (50) tick();
    chk("rst_no_pulse", n_pulse - p0, 0);
    chk("rst_idx", bus.index, 4'b0000);

    // random button traffic with a variable-latency loader
    ld_mode = 2;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(0, 7) == 0) begin
        int b;
        b = int'($urandom_range(0, 4));
        bus.btn_n[b] = ~bus.btn_n[b];
      end
    end
    bus.btn_n = '1;
    repeat (120) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
